// File: rtl/fifo_read_packer_if.sv
// Bundle between the FIFO read side, the packer and the downstream consumer.
// The master modport is the packer's view of this bundle.
interface fifo_read_packer_if #(
   parameter int DATA_WIDTH = 4
);
   logic                    enable;
   logic                    empty;
   logic [DATA_WIDTH-1:0]   rdata;
   logic                    rinc;
   logic [2*DATA_WIDTH-1:0] out_data;
   logic                    out_valid;
   logic                    out_ready;
   logic                    partial;
   logic [7:0]              word_count;

   modport master (
      input  enable, empty, rdata, out_ready,
      output rinc, out_data, out_valid, partial, word_count
   );

   modport slave (
      output enable, empty, rdata, out_ready,
      input  rinc, out_data, out_valid, partial, word_count
   );
endinterface

// File: rtl/fifo_read_packer.sv
// Pops two consecutive FIFO words and presents them as one packed word.
// The first word popped becomes the low half, the second word the high half.
module fifo_read_packer #(
   parameter int DATA_WIDTH = 4
) (
   input logic                clk,
   input logic                rst,
   fifo_read_packer_if.master bus
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT_LO = 3'd1,
      REQ_HI  = 3'd2,
      WAIT_HI = 3'd3,
      PRESENT = 3'd4
   } state_t;

   state_t state;
   state_t state_next;
   logic   pop_req;
   logic   handshake;

   assign handshake = bus.out_valid & bus.out_ready;

   // rinc depends on this cycle's empty flag, so it is decoded from state and
   // inputs; reset masks it so a pop can never start while rst is high.
   assign bus.rinc = pop_req & ~rst;

   // Next-state and pop-request decode.
   always_comb begin
      state_next = state;
      pop_req    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.enable && !bus.empty) begin
               pop_req    = 1'b1;
               state_next = WAIT_LO;
            end else begin
               state_next = IDLE;
            end
         end
         WAIT_LO: begin
            state_next = REQ_HI;
         end
         // Once the low half is held, the word is finished regardless of enable.
         REQ_HI: begin
            if (!bus.empty) begin
               pop_req    = 1'b1;
               state_next = WAIT_HI;
            end else begin
               state_next = REQ_HI;
            end
         end
         WAIT_HI: begin
            state_next = PRESENT;
         end
         PRESENT: begin
            if (handshake && bus.enable && !bus.empty) begin
               pop_req    = 1'b1;
               state_next = WAIT_LO;
            end else if (handshake) begin
               state_next = IDLE;
            end else begin
               state_next = PRESENT;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Half-word capture; rdata is valid in the cycle after each pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_data <= '0;
      end else begin
         case (state)
            WAIT_LO: bus.out_data[DATA_WIDTH-1:0]            <= bus.rdata;
            WAIT_HI: bus.out_data[2*DATA_WIDTH-1:DATA_WIDTH] <= bus.rdata;
            default: bus.out_data                            <= bus.out_data;
         endcase
      end
   end

   // partial covers the gap between the low capture and the high capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.partial <= 1'b0;
      end else begin
         case (state)
            WAIT_LO: bus.partial <= 1'b1;
            WAIT_HI: bus.partial <= 1'b0;
            default: bus.partial <= bus.partial;
         endcase
      end
   end

   // out_valid rises with the completed word and drops on the handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
      end else if (state == WAIT_HI) begin
         bus.out_valid <= 1'b1;
      end else if (handshake) begin
         bus.out_valid <= 1'b0;
      end else begin
         bus.out_valid <= bus.out_valid;
      end
   end

   // Completed-handshake counter, wrapping naturally at 256.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.word_count <= 8'd0;
      end else if (handshake) begin
         bus.word_count <= bus.word_count + 8'd1;
      end else begin
         bus.word_count <= bus.word_count;
      end
   end

endmodule
